// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single unified memory port between instruction fetch
// (IF) and data load/store (D): round-robin on ties, fixed read latency.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_d_q, last_d_d;   // 1: D had the last grant
  logic                sel_d_q, sel_d_d;     // 1: current transaction is D
  logic                we_q, we_d;
  logic                done_q, done_d;       // valid already issued in RESP
  logic                if_gnt_q, if_gnt_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_gnt_q, d_gnt_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                d_wins;

  // D wins when it is the only requester, or on a tie when IF was granted last
  assign d_wins = d_req && (!if_req || !last_d_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    sel_d_d     = sel_d_q;
    we_d        = we_q;
    done_d      = done_q;
    if_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_gnt_d     = 1'b0;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          sel_d_d    = d_wins;
          we_d       = d_wins && d_we;
          last_d_d   = d_wins;
          done_d     = 1'b0;
          mem_addr_d = d_wins ? d_addr : if_addr;
          if (d_wins) mem_wdata_d = d_wdata;
          if_gnt_d   = !d_wins;
          d_gnt_d    = d_wins;
          mem_en_d   = 1'b1;
          mem_we_d   = d_wins && d_we;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (we_q) begin
          d_valid_d = 1'b1;
          done_d    = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = (MEM_LAT > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
          if (sel_d_q) begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      sel_d_q     <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      sel_d_q     <= sel_d_d;
      we_q        <= we_d;
      done_q      <= done_d;
      if_gnt_q    <= if_gnt_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_gnt_q     <= d_gnt_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps, scoreboard of expected
// responses, plus MEM_LAT=1 and MEM_LAT=4 instances for latency checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        if_req, d_req, d_we;
  logic [5:0]  if_addr, d_addr;
  logic [63:0] d_wdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [63:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;

  logic        lat_if_req;
  logic [5:0]  lat_if_addr;
  logic        l1_if_gnt, l1_if_valid, l1_d_gnt, l1_d_valid, l1_mem_en, l1_mem_we, l1_busy;
  logic [63:0] l1_if_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;
  logic [5:0]  l1_mem_addr;
  logic        l4_if_gnt, l4_if_valid, l4_d_gnt, l4_d_valid, l4_mem_en, l4_mem_we, l4_busy;
  logic [63:0] l4_if_rdata, l4_d_rdata, l4_mem_wdata, l4_mem_rdata;
  logic [5:0]  l4_mem_addr;

  typedef struct {
    logic [63:0] data;
    int          at;
  } exp_t;

  exp_t exp_d[$];
  exp_t exp_if[$];
  exp_t mon_e;
  int   gnt_log[$];

  logic [63:0] ram [64];
  logic        ram_ready = 1'b0;
  logic [63:0] p2 [2];
  logic [63:0] p1;
  logic [63:0] p4 [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(64), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(64), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(lat_if_req), .if_addr(lat_if_addr), .if_gnt(l1_if_gnt), .if_valid(l1_if_valid), .if_rdata(l1_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(6'd0), .d_wdata(64'd0),
    .d_gnt(l1_d_gnt), .d_valid(l1_d_valid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(64), .MEM_LAT(4)) dut_l4 (
    .clk(clk), .reset(reset),
    .if_req(lat_if_req), .if_addr(lat_if_addr), .if_gnt(l4_if_gnt), .if_valid(l4_if_valid), .if_rdata(l4_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(6'd0), .d_wdata(64'd0),
    .d_gnt(l4_d_gnt), .d_valid(l4_d_valid), .d_rdata(l4_d_rdata),
    .mem_en(l4_mem_en), .mem_we(l4_mem_we), .mem_addr(l4_mem_addr), .mem_wdata(l4_mem_wdata),
    .mem_rdata(l4_mem_rdata), .busy(l4_busy)
  );

  // RAM model: preload RAM[i] = 0x1000+i, read data delayed MEM_LAT cycles per instance
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= 64'h1000 + 64'(i);
      ram_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    p2[0] <= ram[mem_addr];
    p2[1] <= p2[0];
    p1    <= ram[l1_mem_addr];
    p4[0] <= ram[l4_mem_addr];
    for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
  end

  assign mem_rdata    = p2[1];
  assign l1_mem_rdata = p1;
  assign l4_mem_rdata = p4[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"}, 64'(if_gnt), 0);
    check({tag, "_if_valid"}, 64'(if_valid), 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_gnt"}, 64'(d_gnt), 0);
    check({tag, "_d_valid"}, 64'(d_valid), 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_mem_en"}, 64'(mem_en), 0);
    check({tag, "_mem_we"}, 64'(mem_we), 0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, 64'(busy), 0);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (reset) begin
      if (d_valid) begin
        check("d_valid_expected", 64'(exp_d.size() != 0), 1);
        if (exp_d.size() != 0) begin
          mon_e = exp_d.pop_front();
          check("d_rdata", d_rdata, mon_e.data);
          check("d_valid_cycle", 64'(cyc), 64'(mon_e.at));
        end
      end
      if (if_valid) begin
        check("if_valid_expected", 64'(exp_if.size() != 0), 1);
        if (exp_if.size() != 0) begin
          mon_e = exp_if.pop_front();
          check("if_rdata", if_rdata, mon_e.data);
          check("if_valid_cycle", 64'(cyc), 64'(mon_e.at));
        end
      end
      if (d_gnt) gnt_log.push_back(1);
      if (if_gnt) gnt_log.push_back(0);
    end
  end

  initial begin
    int t;
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    lat_if_req = 1'b0; lat_if_addr = '0;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_l1_busy", 64'(l1_busy), 0);
    check("reset_l4_busy", 64'(l4_busy), 0);
    reset = 1'b1;
    repeat (2) tick();

    // Tie right after reset: D first, then IF
    t = cyc;
    if_req = 1'b1; if_addr = 6'd4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd7;
    exp_d.push_back('{64'h1007, t + 4});
    exp_if.push_back('{64'h1004, t + 9});
    tick();
    check("tie_d_gnt", 64'(d_gnt), 1);
    check("tie_if_gnt_low", 64'(if_gnt), 0);
    check("tie_mem_addr", 64'(mem_addr), 7);
    d_req = 1'b0;
    repeat (4) tick();
    check("tie_if_wait", 64'(if_gnt), 0);
    check("tie_idle_busy", 64'(busy), 0);
    tick();
    check("tie_if_gnt", 64'(if_gnt), 1);
    check("tie_if_addr", 64'(mem_addr), 4);
    if_req = 1'b0;
    repeat (5) tick();

    // Single fetch read of address 3
    t = cyc;
    if_req = 1'b1; if_addr = 6'd3;
    exp_if.push_back('{64'h1003, t + 4});
    tick();
    check("f_if_gnt", 64'(if_gnt), 1);
    check("f_mem_en", 64'(mem_en), 1);
    check("f_mem_we", 64'(mem_we), 0);
    check("f_mem_addr", 64'(mem_addr), 3);
    check("f_busy1", 64'(busy), 1);
    if_req = 1'b0;
    tick();
    check("f_mem_en_off", 64'(mem_en), 0);
    check("f_gnt_off", 64'(if_gnt), 0);
    check("f_busy2", 64'(busy), 1);
    repeat (2) tick();
    check("f_busy4", 64'(busy), 1);
    tick();
    check("f_busy5", 64'(busy), 0);
    tick();

    // Data write, then fetch the written word back
    t = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd5; d_wdata = 64'hDEADBEEF00000001;
    exp_d.push_back('{64'h1007, t + 2});
    tick();
    check("w_d_gnt", 64'(d_gnt), 1);
    check("w_mem_we", 64'(mem_we), 1);
    check("w_mem_addr", 64'(mem_addr), 5);
    check("w_mem_wdata", mem_wdata, 64'hDEADBEEF00000001);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) tick();
    check("w_idle", 64'(busy), 0);
    t = cyc;
    if_req = 1'b1; if_addr = 6'd5;
    exp_if.push_back('{64'hDEADBEEF00000001, t + 4});
    tick();
    check("rb_if_gnt", 64'(if_gnt), 1);
    if_req = 1'b0;
    repeat (5) tick();

    // Both requesters held for six transactions: strict alternation D,F,...
    t = cyc;
    gnt_log.delete();
    if_req = 1'b1; if_addr = 6'd10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd20;
    for (int i = 0; i < 3; i++) begin
      exp_d.push_back('{64'h1014, t + 4 + 10 * i});
      exp_if.push_back('{64'h100A, t + 9 + 10 * i});
    end
    repeat (26) tick();
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) tick();
    check("rr_count", 64'(gnt_log.size()), 6);
    for (int i = 0; i < gnt_log.size() && i < 6; i++) begin
      check($sformatf("rr_order%0d", i), 64'(gnt_log[i]), 64'((i % 2) == 0));
      if (i > 0) check($sformatf("rr_alt%0d", i), 64'(gnt_log[i] != gnt_log[i-1]), 1);
    end

    // Reset during the WAIT of a data read aborts it
    t = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd8;
    tick();
    check("abort_d_gnt", 64'(d_gnt), 1);
    d_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) tick();
    reset = 1'b1;
    repeat (8) tick();
    check("abort_no_valid_busy", 64'(busy), 0);
    t = cyc;
    if_req = 1'b1; if_addr = 6'd2;
    exp_if.push_back('{64'h1002, t + 4});
    tick();
    check("post_if_gnt", 64'(if_gnt), 1);
    if_req = 1'b0;
    repeat (5) tick();

    // Latency builds: MEM_LAT=1 valid at T+3, MEM_LAT=4 valid at T+6
    lat_if_req = 1'b1; lat_if_addr = 6'd9;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) begin
        check("l1_gnt", 64'(l1_if_gnt), 1);
        check("l4_gnt", 64'(l4_if_gnt), 1);
        lat_if_req = 1'b0;
      end
      check($sformatf("l1_valid_t%0d", i), 64'(l1_if_valid), 64'(i == 3));
      check($sformatf("l4_valid_t%0d", i), 64'(l4_if_valid), 64'(i == 6));
      if (i == 3) check("l1_rdata", l1_if_rdata, 64'h1009);
      if (i == 6) check("l4_rdata", l4_if_rdata, 64'h1009);
    end
    repeat (3) tick();

    check("sb_d_empty", 64'(exp_d.size()), 0);
    check("sb_if_empty", 64'(exp_if.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
